// File: rtl/fir_regs_pkg.sv
// Shared constants, region enum and address decoder for the FIR register front end.
package fir_regs_pkg;

   localparam logic [31:0] FIR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] FIR_STATUS = 32'h0000_0004;
   localparam logic [31:0] FIR_IRQEN  = 32'h0000_0008;
   localparam logic [31:0] FIR_X_BASE = 32'h0000_0100;
   localparam logic [31:0] FIR_Y_BASE = 32'h0000_0200;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STATUS,
      REG_IRQEN,
      REG_X,
      REG_Y,
      REG_NONE
   } addr_region_e;

   // Word-aligned decode; the two low address bits never select anything.
   function automatic addr_region_e addr_region(input logic [31:0] addr, input int unsigned nsamp);
      logic [31:0]  word;
      logic [31:0]  span;
      addr_region_e region;
      word = {addr[31:2], 2'b00};
      span = 32'(nsamp) << 2;
      if (word == FIR_CTRL)
         region = REG_CTRL;
      else if (word == FIR_STATUS)
         region = REG_STATUS;
      else if (word == FIR_IRQEN)
         region = REG_IRQEN;
      else if (word >= FIR_X_BASE && word < FIR_X_BASE + span)
         region = REG_X;
      else if (word >= FIR_Y_BASE && word < FIR_Y_BASE + span)
         region = REG_Y;
      else
         region = REG_NONE;
      return region;
   endfunction

endpackage

// File: rtl/axi_lite_fir_regs_if.sv
// AXI4-lite bus bundle; master drives requests, slave drives ready/response.
interface axi_lite_fir_regs_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/fir_sample_ram.sv
// NSAMP x DW sample buffer: one byte-enabled write port, one registered read port.
// Stored as one narrow bank per byte lane so each lane maps cleanly onto block RAM.
module fir_sample_ram #(
   parameter int NSAMP = 32,
   parameter int DW    = 32
) (
   input  logic                     clk_i,
   input  logic                     we,
   input  logic [$clog2(NSAMP)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [DW/8-1:0]          wbe,
   input  logic                     re,
   input  logic [$clog2(NSAMP)-1:0] raddr,
   output logic [DW-1:0]            rdata
);
   localparam int NB = DW / 8;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem [NSAMP];
         logic [7:0] lane_reg;

         // Read-before-write: a same-index read and write in one cycle returns the old byte.
         always_ff @(posedge clk_i) begin
            if (re)
               lane_reg <= mem[raddr];
            if (we && wbe[gi])
               mem[waddr] <= wdata[8*gi +: 8];
         end

         assign rdata[8*gi +: 8] = lane_reg;
      end
   endgenerate
endmodule

// File: rtl/axi_lite_fir_regs.sv
// AXI4-lite register/buffer front end for the FIR core: CTRL/STATUS, X and Y buffers,
// start/done handshake. Optional AXI_LITE_FIR_IRQ_EN adds IRQEN, irq_o and W1C done.
module axi_lite_fir_regs
   import fir_regs_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int NSAMP = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   axi_lite_fir_regs_if.slave       bus,
   output logic                     core_start_o,
   input  logic                     core_done_i,
   input  logic [$clog2(NSAMP)-1:0] x_raddr_i,
   output logic [DW-1:0]            x_rdata_o,
   input  logic                     y_we_i,
   input  logic [$clog2(NSAMP)-1:0] y_waddr_i,
   input  logic [DW-1:0]            y_wdata_i
`ifdef AXI_LITE_FIR_IRQ_EN
   ,
   output logic                     irq_o
`endif
);
   localparam int IW = $clog2(NSAMP);
   localparam int NB = DW / 8;

   logic            ready_en_reg;
   logic            aw_held_reg;
   logic [AW-1:0]   aw_addr_reg;
   logic            w_held_reg;
   logic [DW-1:0]   w_data_reg;
   logic [NB-1:0]   w_strb_reg;
   logic            bvalid_reg;
   logic [1:0]      bresp_reg;
   logic            rvalid_reg;
   logic [1:0]      rresp_reg;
   addr_region_e    r_region_reg;
   logic [DW-1:0]   r_reg_data_reg;
   logic            ctrl_start_reg;
   logic            done_reg;
   logic            busy_reg;
   logic            start_pulse_reg;

   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic            wr_exec;
   addr_region_e    wr_region, rd_region;
   logic [IW-1:0]   wr_idx, rd_idx;
   logic [1:0]      wr_resp, rd_resp;
   logic [DW-1:0]   rd_reg_data;
   logic [DW-1:0]   rdata_mux;
   logic            x_we, ctrl_we, start_req;
   logic [DW-1:0]   x_rdata_arr [2];
   logic [DW-1:0]   y_rdata;
`ifdef AXI_LITE_FIR_IRQ_EN
   logic            irqen_reg;
   logic            irqen_we;
   logic            status_w1c;
`endif

   assign aw_hs   = bus.awvalid && bus.awready;
   assign w_hs    = bus.wvalid && bus.wready;
   assign b_hs    = bus.bvalid && bus.bready;
   assign ar_hs   = bus.arvalid && bus.arready;
   assign r_hs    = bus.rvalid && bus.rready;
   assign wr_exec = aw_held_reg && w_held_reg && !bvalid_reg;

   assign wr_region = addr_region(32'(aw_addr_reg), NSAMP);
   assign wr_idx    = aw_addr_reg[IW+1:2];
   assign rd_region = addr_region(32'(bus.araddr), NSAMP);
   assign rd_idx    = bus.araddr[IW+1:2];

   // Readies stay low until the first clock after reset release.
   assign bus.awready = ready_en_reg && !aw_held_reg && !bvalid_reg;
   assign bus.wready  = ready_en_reg && !w_held_reg && !bvalid_reg;
   assign bus.arready = ready_en_reg && !rvalid_reg;
   assign bus.bvalid  = bvalid_reg;
   assign bus.bresp   = bresp_reg;
   assign bus.rvalid  = rvalid_reg;
   assign bus.rresp   = rresp_reg;
   assign bus.rdata   = rdata_mux;
   assign core_start_o = start_pulse_reg;
   assign x_rdata_o    = x_rdata_arr[0];
`ifdef AXI_LITE_FIR_IRQ_EN
   assign irq_o = done_reg && irqen_reg;
`endif

   // Release the bus readies one cycle after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ready_en_reg <= 1'b0;
      else         ready_en_reg <= 1'b1;
   end

   // AW and W holding registers; both drain together on the B handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_held_reg <= 1'b0;
         aw_addr_reg <= '0;
         w_held_reg  <= 1'b0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
      end else begin
         if (aw_hs) begin
            aw_held_reg <= 1'b1;
            aw_addr_reg <= bus.awaddr;
         end else if (b_hs) begin
            aw_held_reg <= 1'b0;
         end
         if (w_hs) begin
            w_held_reg <= 1'b1;
            w_data_reg <= bus.wdata;
            w_strb_reg <= bus.wstrb;
         end else if (b_hs) begin
            w_held_reg <= 1'b0;
         end
      end
   end

   // Write decode: response code and per-target write enables for the executing write.
   always_comb begin
      wr_resp = RESP_SLVERR;
      x_we    = 1'b0;
      ctrl_we = 1'b0;
`ifdef AXI_LITE_FIR_IRQ_EN
      irqen_we   = 1'b0;
      status_w1c = 1'b0;
`endif
      case (wr_region)
         REG_CTRL: begin
            wr_resp = RESP_OKAY;
            ctrl_we = wr_exec && w_strb_reg[0];
         end
`ifdef AXI_LITE_FIR_IRQ_EN
         REG_STATUS: begin
            wr_resp    = RESP_OKAY;
            status_w1c = wr_exec && w_strb_reg[0] && w_data_reg[0];
         end
         REG_IRQEN: begin
            wr_resp  = RESP_OKAY;
            irqen_we = wr_exec && w_strb_reg[0];
         end
`endif
         REG_X: begin
            // The core may be streaming X while busy, so bus writes are refused then.
            if (!busy_reg) begin
               wr_resp = RESP_OKAY;
               x_we    = wr_exec;
            end
         end
         default: wr_resp = RESP_SLVERR;
      endcase
   end

   assign start_req = ctrl_we && w_data_reg[0] && !ctrl_start_reg && !busy_reg;

   // Write response: one outstanding write, held until the master takes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bvalid_reg <= 1'b0;
         bresp_reg  <= RESP_OKAY;
      end else if (wr_exec) begin
         bvalid_reg <= 1'b1;
         bresp_reg  <= wr_resp;
      end else if (b_hs) begin
         bvalid_reg <= 1'b0;
      end
   end

   // CTRL.start bit and optional IRQ enable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_start_reg <= 1'b0;
`ifdef AXI_LITE_FIR_IRQ_EN
         irqen_reg      <= 1'b0;
`endif
      end else begin
         if (ctrl_we)
            ctrl_start_reg <= w_data_reg[0];
`ifdef AXI_LITE_FIR_IRQ_EN
         if (irqen_we)
            irqen_reg <= w_data_reg[0];
`endif
      end
   end

   // Start/busy/done tracking; a completion in the same cycle as a start wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_pulse_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else if (core_done_i) begin
         start_pulse_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b1;
      end else if (start_req) begin
         start_pulse_reg <= 1'b1;
         busy_reg        <= 1'b1;
         done_reg        <= 1'b0;
      end else begin
         start_pulse_reg <= 1'b0;
`ifdef AXI_LITE_FIR_IRQ_EN
         if (status_w1c)
            done_reg <= 1'b0;
`endif
      end
   end

   // Read decode for register targets; buffer data comes from the RAM read ports.
   always_comb begin
      rd_resp     = RESP_OKAY;
      rd_reg_data = '0;
      case (rd_region)
         REG_CTRL:   rd_reg_data = {{(DW-1){1'b0}}, ctrl_start_reg};
         REG_STATUS: rd_reg_data = {{(DW-2){1'b0}}, busy_reg, done_reg};
`ifdef AXI_LITE_FIR_IRQ_EN
         REG_IRQEN:  rd_reg_data = {{(DW-1){1'b0}}, irqen_reg};
`endif
         REG_X, REG_Y: rd_reg_data = '0;
         default:    rd_resp = RESP_SLVERR;
      endcase
   end

   // Read response: valid the cycle after AR acceptance, held until R handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_reg     <= 1'b0;
         rresp_reg      <= RESP_OKAY;
         r_region_reg   <= REG_NONE;
         r_reg_data_reg <= '0;
      end else if (ar_hs) begin
         rvalid_reg     <= 1'b1;
         rresp_reg      <= rd_resp;
         r_region_reg   <= rd_region;
         r_reg_data_reg <= rd_reg_data;
      end else if (r_hs) begin
         rvalid_reg <= 1'b0;
      end
   end

   // Read data select; RAM outputs only move on a new AR so the value stays stable.
   always_comb begin
      rdata_mux = '0;
      if (rvalid_reg) begin
         case (r_region_reg)
            REG_X:   rdata_mux = x_rdata_arr[1];
            REG_Y:   rdata_mux = y_rdata;
            default: rdata_mux = r_reg_data_reg;
         endcase
      end
   end

   // X is kept as two identical copies so the core and the bus each own a read port.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_x_copy
         fir_sample_ram #(.NSAMP(NSAMP), .DW(DW)) u_x_ram (
            .clk_i (clk_i),
            .we    (x_we),
            .waddr (wr_idx),
            .wdata (w_data_reg),
            .wbe   (w_strb_reg),
            .re    ((gi == 0) ? 1'b1 : (ar_hs && rd_region == REG_X)),
            .raddr ((gi == 0) ? x_raddr_i : rd_idx),
            .rdata (x_rdata_arr[gi])
         );
      end
   endgenerate

   fir_sample_ram #(.NSAMP(NSAMP), .DW(DW)) u_y_ram (
      .clk_i (clk_i),
      .we    (y_we_i),
      .waddr (y_waddr_i),
      .wdata (y_wdata_i),
      .wbe   ({NB{1'b1}}),
      .re    (ar_hs && rd_region == REG_Y),
      .raddr (rd_idx),
      .rdata (y_rdata)
   );

endmodule

// File: tb/tb_axi_lite_fir_regs.sv
// Scoreboard bench for axi_lite_fir_regs; also covers AXI_LITE_FIR_IRQ_EN when defined.
module tb_axi_lite_fir_regs;
   import fir_regs_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      string       tag;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_start;
   logic        core_done;
   logic [4:0]  x_raddr;
   logic [31:0] x_rdata;
   logic        y_we;
   logic [4:0]  y_waddr;
   logic [31:0] y_wdata;
`ifdef AXI_LITE_FIR_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;
   int start_rise = 0;
   int start_hi = 0;
   logic start_prev = 1'b0;
   exp_t wq[$];
   exp_t rq[$];

   axi_lite_fir_regs_if #(.AW(32), .DW(32)) bus ();

   axi_lite_fir_regs #(.AW(32), .DW(32), .NSAMP(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .core_start_o (core_start),
      .core_done_i  (core_done),
      .x_raddr_i    (x_raddr),
      .x_rdata_o    (x_rdata),
      .y_we_i       (y_we),
      .y_waddr_i    (y_waddr),
      .y_wdata_i    (y_wdata)
`ifdef AXI_LITE_FIR_IRQ_EN
      ,
      .irq_o        (irq)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", tag, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every B and R handshake.
   always @(negedge clk_i) begin
      exp_t e;
      if (bus.bvalid && bus.bready) begin
         if (wq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
         else begin
            e = wq.pop_front();
            $display("WR %-12s bresp=%0d", e.tag, bus.bresp);
            check({e.tag, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
         end
      end
      if (bus.rvalid && bus.rready) begin
         if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
         else begin
            e = rq.pop_front();
            $display("RD %-12s rdata=0x%08h rresp=%0d", e.tag, bus.rdata, bus.rresp);
            check({e.tag, "_rdata"}, bus.rdata, e.data);
            check({e.tag, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
         end
      end
   end

   // Start pulse counters: rising edges and high cycles.
   always @(negedge clk_i) begin
      if (core_start && !start_prev) start_rise++;
      if (core_start) start_hi++;
      start_prev = core_start;
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input string tag);
      exp_t e;
      int n;
      logic aw_hs, w_hs, b_hs, fin;
      e.data = '0; e.resp = resp; e.tag = tag;
      wq.push_back(e);
      bus.awaddr = addr; bus.awvalid = 1'b1;
      bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      fin = 1'b0; n = 0;
      while (!fin && n < 40) begin
         @(negedge clk_i);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         b_hs  = bus.bvalid && bus.bready;
         @(posedge clk_i); #1;
         if (aw_hs) bus.awvalid = 1'b0;
         if (w_hs) bus.wvalid = 1'b0;
         if (b_hs) begin bus.bready = 1'b0; fin = 1'b1; end
         n++;
      end
      if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input string tag);
      exp_t e;
      int n;
      logic ar_hs, r_hs, fin;
      e.data = data; e.resp = resp; e.tag = tag;
      rq.push_back(e);
      bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      fin = 1'b0; n = 0;
      while (!fin && n < 40) begin
         @(negedge clk_i);
         ar_hs = bus.arvalid && bus.arready;
         r_hs  = bus.rvalid && bus.rready;
         @(posedge clk_i); #1;
         if (ar_hs) bus.arvalid = 1'b0;
         if (r_hs) begin bus.rready = 1'b0; fin = 1'b1; end
         n++;
      end
      if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic core_finish();
      for (int i = 0; i < 32; i++) begin
         y_we = 1'b1; y_waddr = 5'(i); y_wdata = 32'h0C + 32'(i);
         @(posedge clk_i); #1;
      end
      y_we = 1'b0;
      core_done = 1'b1;
      @(posedge clk_i); #1;
      core_done = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, h0;
      rst_ni = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      core_done = 1'b0; x_raddr = '0; y_we = 1'b0; y_waddr = '0; y_wdata = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
      check("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
      check("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_start", 32'(core_start), 32'd0);
      @(negedge clk_i) rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      axi_read(FIR_STATUS, 32'h0, RESP_OKAY, "status_rst");

      // X fill and readback
      for (int i = 0; i < 32; i++)
         axi_write(FIR_X_BASE + 32'(4*i), 32'(4*i), 4'hF, RESP_OKAY, $sformatf("x%0d_wr", i));
      for (int i = 0; i < 32; i++)
         axi_read(FIR_X_BASE + 32'(4*i), 32'(4*i), RESP_OKAY, $sformatf("x%0d_rd", i));

      // Start, busy, core completion
      s0 = start_rise; h0 = start_hi;
      axi_write(FIR_CTRL, 32'h1, 4'hF, RESP_OKAY, "ctrl_start");
      repeat (3) @(posedge clk_i);
      #1;
      check("start_rises", 32'(start_rise - s0), 32'd1);
      check("start_width", 32'(start_hi - h0), 32'd1);
      axi_read(FIR_STATUS, 32'h2, RESP_OKAY, "status_busy");
      axi_read(FIR_CTRL, 32'h1, RESP_OKAY, "ctrl_rd");
      axi_write(FIR_X_BASE + 32'd20, 32'hAA, 4'hF, RESP_SLVERR, "x5_busy");
      x_raddr = 5'd3;
      @(posedge clk_i); #1;
      check("core_x3", x_rdata, 32'd12);
      core_finish();
      axi_read(FIR_STATUS, 32'h1, RESP_OKAY, "status_done");
      for (int i = 0; i < 32; i += 5)
         axi_read(FIR_Y_BASE + 32'(4*i), 32'h0C + 32'(i), RESP_OKAY, $sformatf("y%0d_rd", i));
      axi_read(FIR_X_BASE + 32'd20, 32'd20, RESP_OKAY, "x5_kept");

      // Byte strobes
      axi_write(FIR_X_BASE + 32'd24, 32'h0, 4'hF, RESP_OKAY, "x6_clr");
      axi_write(FIR_X_BASE + 32'd24, 32'h1234, 4'b0010, RESP_OKAY, "x6_strb");
      axi_read(FIR_X_BASE + 32'd24, 32'h0000_1200, RESP_OKAY, "x6_rd");
      axi_write(FIR_X_BASE + 32'd32, 32'hDEAD, 4'h0, RESP_OKAY, "x8_nostrb");
      axi_read(FIR_X_BASE + 32'd32, 32'd32, RESP_OKAY, "x8_rd");

      // W three cycles ahead of AW, B stalled for five cycles
      begin
         exp_t e;
         e.data = '0; e.resp = RESP_OKAY; e.tag = "wfirst";
         wq.push_back(e);
         bus.bready = 1'b0;
         bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
         @(posedge clk_i); #1;
         bus.wdata = 32'h99;
         repeat (2) @(posedge clk_i);
         #1;
         check("w_held_wready", 32'(bus.wready), 32'd0);
         bus.awaddr = FIR_X_BASE + 32'd28; bus.awvalid = 1'b1;
         @(posedge clk_i); #1;
         bus.awvalid = 1'b0;
         @(posedge clk_i); #1;
         for (int k = 0; k < 5; k++) begin
            check("b_hold_valid", 32'(bus.bvalid), 32'd1);
            check("b_hold_ready", {30'd0, bus.awready, bus.wready}, 32'd0);
            @(posedge clk_i); #1;
         end
         bus.wvalid = 1'b0; bus.bready = 1'b1;
         @(posedge clk_i); #1;
         bus.bready = 1'b0;
         @(posedge clk_i); #1;
         check("b_single", 32'(bus.bvalid), 32'd0);
      end
      axi_read(FIR_X_BASE + 32'd28, 32'h77, RESP_OKAY, "x7_rd");

      // Error responses
      axi_write(32'h300, 32'h5, 4'hF, RESP_SLVERR, "unmap_wr");
      axi_read(32'h3FC, 32'h0, RESP_SLVERR, "unmap_rd");
      axi_write(FIR_Y_BASE, 32'hFF, 4'hF, RESP_SLVERR, "y0_wr");
      axi_read(FIR_Y_BASE, 32'h0C, RESP_OKAY, "y0_kept");
`ifndef AXI_LITE_FIR_IRQ_EN
      axi_write(FIR_STATUS, 32'h1, 4'hF, RESP_SLVERR, "status_wr");
      axi_read(FIR_IRQEN, 32'h0, RESP_SLVERR, "irqen_unmap");
      axi_read(FIR_STATUS, 32'h1, RESP_OKAY, "status_ro");
`endif

      // Restart requires a 0 write first
      s0 = start_rise;
      axi_write(FIR_CTRL, 32'h1, 4'hF, RESP_OKAY, "ctrl_again");
      repeat (2) @(posedge clk_i);
      #1;
      check("no_restart", 32'(start_rise - s0), 32'd0);
      axi_write(FIR_CTRL, 32'h0, 4'hF, RESP_OKAY, "ctrl_zero");
      axi_write(FIR_CTRL, 32'h1, 4'hF, RESP_OKAY, "ctrl_restart");
      repeat (2) @(posedge clk_i);
      #1;
      check("restart_rise", 32'(start_rise - s0), 32'd1);
      axi_read(FIR_STATUS, 32'h2, RESP_OKAY, "status_busy2");
      core_finish();
      axi_read(FIR_STATUS, 32'h1, RESP_OKAY, "status_done2");

`ifdef AXI_LITE_FIR_IRQ_EN
      check("irq_masked", 32'(irq), 32'd0);
      axi_write(FIR_IRQEN, 32'h1, 4'hF, RESP_OKAY, "irqen_wr");
      axi_read(FIR_IRQEN, 32'h1, RESP_OKAY, "irqen_rd");
      check("irq_set", 32'(irq), 32'd1);
      axi_write(FIR_STATUS, 32'h1, 4'hF, RESP_OKAY, "status_w1c");
      check("irq_clr", 32'(irq), 32'd0);
      axi_read(FIR_STATUS, 32'h0, RESP_OKAY, "status_clr");
`endif

      // Reset with a read outstanding
      bus.araddr = FIR_STATUS; bus.arvalid = 1'b1; bus.rready = 1'b0;
      @(posedge clk_i); #1;
      bus.arvalid = 1'b0;
      check("ar_pending", 32'(bus.rvalid), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_start2", 32'(core_start), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      @(negedge clk_i) rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      axi_read(FIR_STATUS, 32'h0, RESP_OKAY, "status_rst2");
      axi_read(FIR_CTRL, 32'h0, RESP_OKAY, "ctrl_rst2");

      repeat (2) @(posedge clk_i);
      check("wq_empty", 32'(wq.size()), 32'd0);
      check("rq_empty", 32'(rq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
